// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder datapath.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;
    localparam int SHIFT_W = 5;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    // Normalized result as produced by the post-add normalization stage.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] frac;
        logic              zero;
        logic              ovf;
        logic              unf;
    } fp_norm_t;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter for the 24-bit mantissa.
// A zero input reports 24; callers detect zero separately.
module fp_lzc24
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0]  mant,
    output logic [SHIFT_W-1:0] lz
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        lz = SHIFT_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) begin
                lz = SHIFT_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_stage.sv
// Post-add normalization: stage 1 counts leading zeros, stage 2 shifts,
// adjusts the exponent and classifies overflow/underflow/zero.
// Rounding is truncation; denormals are flushed to zero.
module fp_normalize_stage
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-2:0] out_frac,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    logic               s1_valid;
    logic               s1_sign;
    logic [EXP_W-1:0]   s1_exp;
    logic [MANT_W-1:0]  s1_mant;
    logic               s1_carry;
    logic [SHIFT_W-1:0] s1_lz;
    logic               s1_mz;

    logic               s2_valid;
    fp_norm_t           s2_res;

    logic               s1_adv;
    logic [SHIFT_W-1:0] in_lz;
    fp_norm_t           nxt_res;
    logic [EXP_W:0]     exp_inc;
    logic [EXP_W-1:0]   lz_ext;
    logic [MANT_W-1:0]  shifted;

    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    fp_lzc24 u_lzc (
        .mant (in_mant),
        .lz   (in_lz)
    );

    // Stage 1: capture the raw sum together with its leading-zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_carry <= 1'b0;
            s1_lz    <= '0;
            s1_mz    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_exp   <= in_exp;
                s1_mant  <= in_mant;
                s1_carry <= in_carry;
                s1_lz    <= in_lz;
                s1_mz    <= (in_mant == '0);
            end
        end
    end

    // Stage 2 datapath: classify in priority order and normalize.
    always_comb begin
        nxt_res      = '0;
        nxt_res.sign = s1_sign;
        exp_inc      = {1'b0, s1_exp} + (EXP_W+1)'(1);
        lz_ext       = {{(EXP_W-SHIFT_W){1'b0}}, s1_lz};
        shifted      = s1_mant << s1_lz;
        if (s1_exp == EXP_MAX) begin
            nxt_res.ovf = 1'b1;
            nxt_res.exp = EXP_MAX;
        end else if (s1_carry) begin
            // Carry-out: the hidden bit moves up one place, so shift right by one.
            if (exp_inc >= {1'b0, EXP_MAX}) begin
                nxt_res.ovf = 1'b1;
                nxt_res.exp = EXP_MAX;
            end else begin
                nxt_res.exp  = exp_inc[EXP_W-1:0];
                nxt_res.frac = s1_mant[MANT_W-1:1];
            end
        end else if (s1_mz) begin
            nxt_res.sign = 1'b0;
            nxt_res.zero = 1'b1;
        end else if (lz_ext >= s1_exp) begin
            // Result would be denormal or below; flush to signed zero.
            nxt_res.unf = 1'b1;
        end else begin
            nxt_res.exp  = s1_exp - lz_ext;
            nxt_res.frac = shifted[MANT_W-2:0];
        end
    end

    // Stage 2 register: advances only when the output slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= nxt_res;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_sign  = s2_res.sign;
    assign out_exp   = s2_res.exp;
    assign out_frac  = s2_res.frac;
    assign out_zero  = s2_res.zero;
    assign out_ovf   = s2_res.ovf;
    assign out_unf   = s2_res.unf;

endmodule

// File: tb/tb_fp_normalize_stage.sv
// Self-checking bench for fp_normalize_stage: directed vectors, randomized
// traffic with random backpressure, stall stability and mid-flight reset.
module tb_fp_normalize_stage;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int checks = 0;
    int errors = 0;
    fp_norm_t exp_q[$];

    always #5 clk = ~clk;

    fp_normalize_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // Reference: value-level normalization using arithmetic on integers.
    function automatic fp_norm_t ref_norm(input logic s, input int e, input int m, input logic c);
        fp_norm_t r;
        int mm;
        int sh;
        r = '0;
        r.sign = s;
        if (e == 255) begin
            r.ovf = 1'b1;
            r.exp = 8'd255;
        end else if (c) begin
            if (e + 1 >= 255) begin
                r.ovf = 1'b1;
                r.exp = 8'd255;
            end else begin
                r.exp  = 8'(e + 1);
                r.frac = 23'(((16777216 + m) / 2) % 8388608);
            end
        end else if (m == 0) begin
            r.sign = 1'b0;
            r.zero = 1'b1;
        end else begin
            mm = m;
            sh = 0;
            while (mm < 8388608) begin
                mm = mm * 2;
                sh++;
            end
            if (sh >= e) begin
                r.unf = 1'b1;
            end else begin
                r.exp  = 8'(e - sh);
                r.frac = 23'(mm % 8388608);
            end
        end
        return r;
    endfunction

    function automatic fp_norm_t obs_now();
        fp_norm_t o;
        o.sign = out_sign;
        o.exp  = out_exp;
        o.frac = out_frac;
        o.zero = out_zero;
        o.ovf  = out_ovf;
        o.unf  = out_unf;
        return o;
    endfunction

    task automatic rand_beat();
        logic [31:0] r;
        in_sign  = 1'($urandom_range(0, 1));
        in_carry = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 5))
            0:       in_exp = 8'd255;
            1:       in_exp = 8'd254;
            2:       in_exp = 8'($urandom_range(0, 24));
            default: in_exp = 8'($urandom_range(0, 255));
        endcase
        r = $urandom();
        if ($urandom_range(0, 9) == 0) in_mant = 24'h0;
        else in_mant = 24'(r >> $urandom_range(8, 31));
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (obs_now() !== fp_norm_t'('0)) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", obs_now());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
    endtask

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        c;
        fp_norm_t    want;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        fp_norm_t o;
        //                 sign  exp    mant        carry   {sign, exp, frac, zero, ovf, unf}
        v.push_back('{1'b0, 8'h80, 24'h800000, 1'b0, '{1'b0, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b0}});
        v.push_back('{1'b0, 8'h80, 24'h400001, 1'b1, '{1'b0, 8'h81, 23'h200000, 1'b0, 1'b0, 1'b0}});
        v.push_back('{1'b1, 8'hFE, 24'h123456, 1'b1, '{1'b1, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0}});
        v.push_back('{1'b0, 8'h85, 24'h000F00, 1'b0, '{1'b0, 8'h79, 23'h700000, 1'b0, 1'b0, 1'b0}});
        v.push_back('{1'b1, 8'h03, 24'h000100, 1'b0, '{1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1}});
        v.push_back('{1'b1, 8'h90, 24'h000000, 1'b0, '{1'b0, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0}});
        v.push_back('{1'b1, 8'hFF, 24'h400000, 1'b0, '{1'b1, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0}});
        v.push_back('{1'b0, 8'h0D, 24'h000800, 1'b0, '{1'b0, 8'h01, 23'h000000, 1'b0, 1'b0, 1'b0}});
        v.push_back('{1'b0, 8'h0C, 24'h000800, 1'b0, '{1'b0, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1}});
        v.push_back('{1'b1, 8'hFD, 24'hFFFFFF, 1'b1, '{1'b1, 8'hFE, 23'h7FFFFF, 1'b0, 1'b0, 1'b0}});
        v.push_back('{1'b1, 8'h00, 24'h800000, 1'b0, '{1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1}});
        foreach (v[i]) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_sign   = v[i].s;
            in_exp    = v[i].e;
            in_mant   = v[i].m;
            in_carry  = v[i].c;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed %0d in_ready: got %b expected 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed %0d early out_valid: got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            o = obs_now();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed %0d latency out_valid: got %b expected 1", i, out_valid);
            end
            checks++;
            if (o !== v[i].want) begin
                errors++;
                $display("FAIL directed %0d result: got %h expected %h", i, o, v[i].want);
            end
        end
    endtask

    task automatic test_random(input int n);
        int sent = 0;
        int got = 0;
        int cycles = 0;
        fp_norm_t want;
        fp_norm_t o;
        exp_q.delete();
        while (got < n && cycles < 20 * n) begin
            @(negedge clk);
            cycles++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                want = exp_q.pop_front();
                o = obs_now();
                checks++;
                if (o !== want) begin
                    errors++;
                    $display("FAIL random beat %0d: got %h expected %h", got, o, want);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_norm(in_sign, int'(in_exp), int'(in_mant), in_carry));
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL random count: got %0d beats expected %0d", got, n);
        end
    endtask

    task automatic test_back_to_back();
        logic        bs[4];
        logic [7:0]  be[4];
        logic [23:0] bm[4];
        logic        bc[4];
        int accepted = 0;
        int got = 0;
        int cycles = 0;
        logic have = 1'b0;
        fp_norm_t held;
        fp_norm_t o;
        fp_norm_t want;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            bs[i] = in_sign;
            be[i] = (in_exp == 8'd255) ? 8'd100 : in_exp;
            bm[i] = in_mant | 24'h000010;
            bc[i] = in_carry;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (accepted < 4);
            if (accepted < 4) begin
                in_sign  = bs[accepted];
                in_exp   = be[accepted];
                in_mant  = bm[accepted];
                in_carry = bc[accepted];
            end
            #1;
            if (out_valid) begin
                o = obs_now();
                if (have) begin
                    checks++;
                    if (o !== held) begin
                        errors++;
                        $display("FAIL stall stability: got %h expected %h", o, held);
                    end
                end
                held = o;
                have = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_norm(in_sign, int'(in_exp), int'(in_mant), in_carry));
                accepted++;
            end
        end
        checks++;
        if (accepted != 2) begin
            errors++;
            $display("FAIL stall accepted: got %0d expected 2", accepted);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall in_ready: got %b expected 0", in_ready);
        end
        while (got < 4 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            out_ready = 1'b1;
            in_valid  = (accepted < 4);
            if (accepted < 4) begin
                in_sign  = bs[accepted];
                in_exp   = be[accepted];
                in_mant  = bm[accepted];
                in_carry = bc[accepted];
            end
            #1;
            if (out_valid && out_ready) begin
                want = exp_q.pop_front();
                o = obs_now();
                checks++;
                if (o !== want) begin
                    errors++;
                    $display("FAIL back_to_back beat %0d: got %h expected %h", got, o, want);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_norm(in_sign, int'(in_exp), int'(in_mant), in_carry));
                accepted++;
            end
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (out_valid) got++;
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL back_to_back count: got %0d beats expected 4", got);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 8'h80;
        in_mant   = 24'h800000;
        in_carry  = 1'b0;
        @(negedge clk);
        in_mant = 24'h400000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight pre-reset out_valid: got %b expected 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (obs_now() !== fp_norm_t'('0)) begin
            errors++;
            $display("FAIL midflight outputs: got %h expected 0", obs_now());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight in_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight stale beat cycle %0d: got %b expected 0", c, out_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random(400);
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
